// File: rtl/patt_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
package patt_det_pkg;

  localparam int PATT_W_MAX = 32;

  typedef enum logic {
    MODE_NONOVERLAP = 1'b0,
    MODE_OVERLAP    = 1'b1
  } mode_e;

  function automatic int fill_width(input int patt_w);
    return $clog2(patt_w + 1);
  endfunction

endpackage

// File: rtl/patt_shift_window.sv
// Qualified serial shift window with a saturating fill counter.
module patt_shift_window
  import patt_det_pkg::*;
#(
  parameter int PATT_W = 4,
  parameter int FILL_W = fill_width(PATT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  input  logic              input_en,
  input  logic              fill_clr,
  output logic [PATT_W-1:0] next_window,
  output logic [FILL_W-1:0] next_fill,
  output logic [PATT_W-1:0] window
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATT_W);

  logic [FILL_W-1:0] fill;

  always_comb begin
    next_window = window;
    next_fill   = fill;
    if (input_en) begin
      next_window = {window[PATT_W-2:0], data_in};
      if (fill != FILL_FULL) next_fill = fill + FILL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      window <= '0;
      fill   <= '0;
    end else begin
      window <= next_window;
      fill   <= fill_clr ? '0 : next_fill;
    end
  end

endmodule

// File: rtl/patt_detector_n.sv
// Serial pattern detector: masked compare of the shift window against a live
// pattern, registered match pulse and saturating match counter.
module patt_detector_n
  import patt_det_pkg::*;
#(
  parameter int PATT_W = 4,
  parameter int CNT_W  = 8,
  parameter int FILL_W = fill_width(PATT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_in,
  input  logic              input_en,
  input  logic [PATT_W-1:0] pattern,
  input  logic [PATT_W-1:0] mask,
  input  logic              overlap_en,
  input  logic              clr_cnt,
  output logic              match,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              window_valid
);

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  if (PATT_W < 2 || PATT_W > PATT_W_MAX) begin : g_bad_patt_w
    $error("patt_detector_n: PATT_W out of range");
  end

  logic [PATT_W-1:0] next_window;
  logic [PATT_W-1:0] window;
  logic [FILL_W-1:0] next_fill;
  logic              hit;
  logic              fill_clr;

  patt_shift_window #(
    .PATT_W (PATT_W),
    .FILL_W (FILL_W)
  ) u_window (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .input_en    (input_en),
    .fill_clr    (fill_clr),
    .next_window (next_window),
    .next_fill   (next_fill),
    .window      (window)
  );

  // Compare on the post-shift window so the pulse lands one clock after the final bit.
  always_comb begin
    hit      = input_en
               && (((next_window ^ pattern) & mask) == '0)
               && (next_fill == FILL_FULL);
    fill_clr = hit && (mode_e'(overlap_en) == MODE_NONOVERLAP);
  end

  // Idle cycles must leave the window untouched.
  always_comb begin
    if (!input_en) assert (next_window == window);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      match        <= 1'b0;
      match_cnt    <= '0;
      window_valid <= 1'b0;
    end else begin
      match        <= hit;
      window_valid <= !fill_clr && (next_fill == FILL_FULL);
      if (clr_cnt)
        match_cnt <= hit ? CNT_W'(1) : '0;
      else if (hit && match_cnt != CNT_MAX)
        match_cnt <= match_cnt + CNT_W'(1);
    end
  end

endmodule
